// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out ROB tags at dispatch, captures writeback results,
// answers operand lookups and commits in program order with a one-cycle rollback after a mispredict.
module reorder_buffer #(
    parameter int ROB_ENTRY_NUM   = 16,
    parameter int ROB_ENTRY_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd,
    output logic                       alloc_ready,
    output logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
    input  logic                       wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] wb_index,
    input  logic [31:0]                wb_data,
    input  logic                       wb_mispredict,
    input  logic [ROB_ENTRY_WIDTH-1:0] q1_index,
    output logic                       q1_ready,
    output logic [31:0]                q1_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] q2_index,
    output logic                       q2_ready,
    output logic [31:0]                q2_data,
    output logic                       commit_we,
    output logic [4:0]                 commit_addr,
    output logic [31:0]                commit_data,
    output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
    output logic                       rollback,
    output logic                       empty,
    output logic                       full
);
    localparam logic [ROB_ENTRY_WIDTH:0]   FULL_COUNT = (ROB_ENTRY_WIDTH+1)'(ROB_ENTRY_NUM);
    localparam logic [ROB_ENTRY_WIDTH:0]   COUNT_ONE  = (ROB_ENTRY_WIDTH+1)'(1);
    localparam logic [ROB_ENTRY_WIDTH-1:0] PTR_ONE    = ROB_ENTRY_WIDTH'(1);

    logic [ROB_ENTRY_WIDTH-1:0] head_r;
    logic [ROB_ENTRY_WIDTH-1:0] tail_r;
    logic [ROB_ENTRY_WIDTH:0]   count_r;
    logic [ROB_ENTRY_NUM-1:0]   busy_r;
    logic [ROB_ENTRY_NUM-1:0]   done_r;
    logic [ROB_ENTRY_NUM-1:0]   mispredict_r;
    logic [4:0]                 rd_r   [ROB_ENTRY_NUM];
    logic [31:0]                data_r [ROB_ENTRY_NUM];
    logic                       flush_pending_r;
    logic                       rollback_r;

    logic                       commit_fire_s;
    logic                       head_mispredict_commit_s;
    logic                       alloc_fire_s;
    logic                       full_s;
    logic [ROB_ENTRY_WIDTH:0]   count_next_s;

    assign full_s                   = (count_r == FULL_COUNT);
    assign commit_fire_s            = busy_r[head_r] && done_r[head_r] && !flush_pending_r;
    assign head_mispredict_commit_s = commit_fire_s && mispredict_r[head_r];
    assign alloc_fire_s             = alloc_valid && alloc_ready;

    assign full         = full_s;
    assign empty        = (count_r == '0);
    assign alloc_ready  = !full_s && !flush_pending_r && !head_mispredict_commit_s;
    assign alloc_index  = tail_r;
    assign commit_index = head_r;
    assign commit_addr  = rd_r[head_r];
    assign commit_data  = data_r[head_r];
    assign commit_we    = commit_fire_s && (rd_r[head_r] != 5'd0);
    assign rollback     = rollback_r;

    // Occupancy update; a same-cycle allocate and commit cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({alloc_fire_s, commit_fire_s})
            2'b10:   count_next_s = count_r + COUNT_ONE;
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Operand lookups, forwarding a same-cycle writeback to a busy entry.
    always_comb begin
        q1_ready = 1'b0;
        q1_data  = data_r[q1_index];
        q2_ready = 1'b0;
        q2_data  = data_r[q2_index];
        if (busy_r[q1_index] && wb_valid && (wb_index == q1_index)) begin
            q1_ready = 1'b1;
            q1_data  = wb_data;
        end else begin
            q1_ready = busy_r[q1_index] && done_r[q1_index];
            q1_data  = data_r[q1_index];
        end
        if (busy_r[q2_index] && wb_valid && (wb_index == q2_index)) begin
            q2_ready = 1'b1;
            q2_data  = wb_data;
        end else begin
            q2_ready = busy_r[q2_index] && done_r[q2_index];
            q2_data  = data_r[q2_index];
        end
    end

    // Entry state, pointers and flush sequencing; the flush cycle discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r          <= '0;
            tail_r          <= '0;
            count_r         <= '0;
            busy_r          <= '0;
            done_r          <= '0;
            mispredict_r    <= '0;
            flush_pending_r <= 1'b0;
            rollback_r      <= 1'b0;
            for (int i = 0; i < ROB_ENTRY_NUM; i++) begin
                rd_r[i]   <= 5'd0;
                data_r[i] <= 32'd0;
            end
        end else if (flush_pending_r) begin
            head_r          <= '0;
            tail_r          <= '0;
            count_r         <= '0;
            busy_r          <= '0;
            flush_pending_r <= 1'b0;
            rollback_r      <= 1'b0;
        end else begin
            if (wb_valid && busy_r[wb_index]) begin
                done_r[wb_index]       <= 1'b1;
                data_r[wb_index]       <= wb_data;
                mispredict_r[wb_index] <= wb_mispredict;
            end
            if (alloc_fire_s) begin
                busy_r[tail_r]       <= 1'b1;
                done_r[tail_r]       <= 1'b0;
                mispredict_r[tail_r] <= 1'b0;
                rd_r[tail_r]         <= alloc_rd;
                tail_r               <= tail_r + PTR_ONE;
            end
            if (commit_fire_s) begin
                busy_r[head_r] <= 1'b0;
                head_r         <= head_r + PTR_ONE;
            end
            count_r         <= count_next_s;
            flush_pending_r <= head_mispredict_commit_s;
            rollback_r      <= head_mispredict_commit_s;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus a randomized run against a
// program-order queue model of the buffer.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [3:0]  alloc_index;
    logic        wb_valid;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;
    logic        wb_mispredict;
    logic [3:0]  q1_index, q2_index;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        commit_we;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  commit_index;
    logic        rollback, empty, full;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_ENTRY_NUM(16), .ROB_ENTRY_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict),
        .q1_index(q1_index), .q1_ready(q1_ready), .q1_data(q1_data),
        .q2_index(q2_index), .q2_ready(q2_ready), .q2_data(q2_data),
        .commit_we(commit_we), .commit_addr(commit_addr),
        .commit_data(commit_data), .commit_index(commit_index),
        .rollback(rollback), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Program-order model: one queue element per live instruction, oldest first.
    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  rd;
        bit          done;
        bit          misp;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    int unsigned m_tail;
    bit          m_flush;
    bit          m_rollback;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = 5'd0;
        wb_valid = 1'b0; wb_index = 4'd0; wb_data = 32'd0; wb_mispredict = 1'b0;
        q1_index = 4'd0; q2_index = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic void model_lookup(input logic [3:0] qi, output bit rdy,
                                         output logic [31:0] d);
        rdy = 1'b0;
        d   = 32'd0;
        foreach (mq[k]) begin
            if (mq[k].idx == qi) begin
                if (wb_valid && wb_index == qi) begin
                    rdy = 1'b1; d = wb_data;
                end else if (mq[k].done) begin
                    rdy = 1'b1; d = mq[k].data;
                end
            end
        end
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({empty, full, alloc_ready, alloc_index, commit_we, rollback} !== 9'b1_0_1_0000_0_0) begin
            errors++;
            $display("FAIL reset: empty/full/ready/idx/we/rb = %b%b%b_%h_%b%b required 101_0_00",
                     empty, full, alloc_ready, alloc_index, commit_we, rollback);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc_valid = 1'b1; alloc_rd = 5'd5; #1;
        checks++;
        if (alloc_index !== 4'd0) begin errors++; $display("FAIL inorder_idx0: got %0d required 0", alloc_index); end
        tick();
        alloc_rd = 5'd6; #1;
        checks++;
        if (alloc_index !== 4'd1) begin errors++; $display("FAIL inorder_idx1: got %0d required 1", alloc_index); end
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_index = 4'd1; wb_data = 32'h22; #1;
        checks++;
        if (commit_we !== 1'b0) begin errors++; $display("FAIL inorder_early: commit_we=%b required 0", commit_we); end
        tick();
        wb_valid = 1'b0;
        tick();
        wb_valid = 1'b1; wb_index = 4'd0; wb_data = 32'h11; #1;
        checks++;
        if (commit_we !== 1'b0) begin errors++; $display("FAIL inorder_wb_head: commit_we=%b required 0", commit_we); end
        tick();
        wb_valid = 1'b0; #1;
        checks++;
        if ({commit_we, commit_addr, commit_data, commit_index} !== {1'b1, 5'd5, 32'h11, 4'd0}) begin
            errors++;
            $display("FAIL inorder_c0: we=%b addr=%0d data=%h idx=%0d required 1/5/11/0",
                     commit_we, commit_addr, commit_data, commit_index);
        end
        tick();
        checks++;
        if ({commit_we, commit_addr, commit_data, commit_index} !== {1'b1, 5'd6, 32'h22, 4'd1}) begin
            errors++;
            $display("FAIL inorder_c1: we=%b addr=%0d data=%h idx=%0d required 1/6/22/1",
                     commit_we, commit_addr, commit_data, commit_index);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL inorder_empty: empty=%b required 1", empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
            tick();
        end
        alloc_valid = 1'b0; #1;
        checks++;
        if ({full, alloc_ready} !== 2'b10) begin
            errors++; $display("FAIL full: full=%b ready=%b required 1/0", full, alloc_ready);
        end
        wb_valid = 1'b1; wb_index = 4'd0; wb_data = 32'h100;
        tick();
        wb_valid = 1'b0; #1;
        checks++;
        if ({commit_we, commit_index, alloc_ready} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL full_commit: we=%b idx=%0d ready=%b required 1/0/0", commit_we, commit_index, alloc_ready);
        end
        tick();
        checks++;
        if ({alloc_ready, alloc_index, full} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL wrap: ready=%b idx=%0d full=%b required 1/0/0", alloc_ready, alloc_index, full);
        end
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_valid = 1'b0; #1;
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL refill: full=%b required 1", full); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        tick();
        alloc_rd = 5'd9; wb_valid = 1'b1; wb_index = 4'd0; wb_data = 32'hDEAD;
        tick();
        alloc_valid = 1'b0; wb_index = 4'd1; wb_data = 32'hBEEF; #1;
        checks++;
        if ({commit_we, commit_index} !== {1'b0, 4'd0}) begin
            errors++; $display("FAIL rd0_pop: we=%b idx=%0d required 0/0", commit_we, commit_index);
        end
        tick();
        wb_valid = 1'b0; #1;
        checks++;
        if ({commit_we, commit_addr, commit_data, commit_index} !== {1'b1, 5'd9, 32'hBEEF, 4'd1}) begin
            errors++;
            $display("FAIL rd0_next: we=%b addr=%0d data=%h idx=%0d required 1/9/beef/1",
                     commit_we, commit_addr, commit_data, commit_index);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_index = 4'd1; wb_data = 32'h41; tick();
        wb_index = 4'd2; wb_data = 32'h42; tick();
        wb_index = 4'd0; wb_data = 32'h40; wb_mispredict = 1'b1; tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0; #1;
        checks++;
        if ({commit_we, commit_addr, commit_data, commit_index, rollback, alloc_ready} !==
            {1'b1, 5'd1, 32'h40, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misp_commit: we=%b addr=%0d data=%h idx=%0d rb=%b ready=%b required 1/1/40/0/0/0",
                     commit_we, commit_addr, commit_data, commit_index, rollback, alloc_ready);
        end
        tick();
        wb_valid = 1'b1; wb_index = 4'd1; wb_data = 32'h99; #1;
        checks++;
        if ({rollback, commit_we, alloc_ready} !== 3'b100) begin
            errors++; $display("FAIL misp_rollback: rb=%b we=%b ready=%b required 1/0/0", rollback, commit_we, alloc_ready);
        end
        tick();
        wb_valid = 1'b0; q1_index = 4'd1; #1;
        checks++;
        if ({rollback, empty, alloc_index, commit_we, q1_ready} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misp_after: rb=%b empty=%b idx=%0d we=%b q1r=%b required 0/1/0/0/0",
                     rollback, empty, alloc_index, commit_we, q1_ready);
        end
        tick();
        checks++;
        if ({rollback, commit_we, empty} !== 3'b001) begin
            errors++; $display("FAIL misp_quiet: rb=%b we=%b empty=%b required 0/0/1", rollback, commit_we, empty);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(10 + i);
            tick();
        end
        alloc_valid = 1'b0; q1_index = 4'd3; q2_index = 4'd2; #1;
        checks++;
        if (q1_ready !== 1'b0) begin errors++; $display("FAIL byp_notready: q1_ready=%b required 0", q1_ready); end
        wb_valid = 1'b1; wb_index = 4'd3; wb_data = 32'h77; #1;
        checks++;
        if ({q1_ready, q1_data, q2_ready} !== {1'b1, 32'h77, 1'b0}) begin
            errors++;
            $display("FAIL byp_same: q1r=%b q1d=%h q2r=%b required 1/77/0", q1_ready, q1_data, q2_ready);
        end
        tick();
        wb_valid = 1'b0; q2_index = 4'd3; #1;
        checks++;
        if ({q1_ready, q1_data, q2_ready, q2_data} !== {1'b1, 32'h77, 1'b1, 32'h77}) begin
            errors++;
            $display("FAIL byp_next: q1r=%b q1d=%h q2r=%b q2d=%h required 1/77/1/77",
                     q1_ready, q1_data, q2_ready, q2_data);
        end
    endtask

    task automatic test_random();
        bit          e_commit, e_misp, e_full, e_ready, e_we, r1, r2;
        logic [31:0] d1, d2;
        logic [8:0]  e_ctrl;
        ent_t        e;
        do_reset();
        mq.delete();
        m_tail = 0; m_flush = 1'b0; m_rollback = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            alloc_valid   = ($urandom_range(0, 99) < 60);
            alloc_rd      = 5'($urandom_range(0, 31));
            wb_valid      = ($urandom_range(0, 99) < 55);
            wb_data       = $urandom;
            wb_mispredict = ($urandom_range(0, 99) < 4);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                wb_index = mq[$urandom_range(0, mq.size() - 1)].idx;
            else
                wb_index = 4'($urandom_range(0, 15));
            q1_index = 4'($urandom_range(0, 15));
            q2_index = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].idx : 4'd0;
            #1;
            e_commit = (mq.size() > 0) && mq[0].done && !m_flush;
            e_misp   = e_commit && mq[0].misp;
            e_full   = (mq.size() == 16);
            e_ready  = !e_full && !m_flush && !e_misp;
            e_we     = e_commit && (mq[0].rd != 5'd0);
            e_ctrl   = {e_ready, 4'(m_tail), e_full, (mq.size() == 0), e_we, m_rollback};
            checks++;
            if ({alloc_ready, alloc_index, full, empty, commit_we, rollback} !== e_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: ready/idx/full/empty/we/rb = %b required %b", cyc,
                         {alloc_ready, alloc_index, full, empty, commit_we, rollback}, e_ctrl);
            end
            if (e_commit) begin
                checks++;
                if ({commit_index, commit_addr, commit_data} !== {mq[0].idx, mq[0].rd, mq[0].data}) begin
                    errors++;
                    $display("FAIL rand_commit cyc %0d: idx=%0d addr=%0d data=%h required %0d/%0d/%h", cyc,
                             commit_index, commit_addr, commit_data, mq[0].idx, mq[0].rd, mq[0].data);
                end
            end
            model_lookup(q1_index, r1, d1);
            model_lookup(q2_index, r2, d2);
            checks++;
            if (q1_ready !== r1 || (r1 && q1_data !== d1)) begin
                errors++;
                $display("FAIL rand_q1 cyc %0d: ready=%b data=%h required %b/%h", cyc, q1_ready, q1_data, r1, d1);
            end
            checks++;
            if (q2_ready !== r2 || (r2 && q2_data !== d2)) begin
                errors++;
                $display("FAIL rand_q2 cyc %0d: ready=%b data=%h required %b/%h", cyc, q2_ready, q2_data, r2, d2);
            end
            tick();
            if (m_flush) begin
                mq.delete();
                m_tail = 0; m_flush = 1'b0; m_rollback = 1'b0;
            end else begin
                if (wb_valid) begin
                    foreach (mq[k]) begin
                        if (mq[k].idx == wb_index) begin
                            e = mq[k];
                            e.done = 1'b1; e.data = wb_data; e.misp = wb_mispredict;
                            mq[k] = e;
                        end
                    end
                end
                if (e_commit) void'(mq.pop_front());
                if (alloc_valid && e_ready) begin
                    e = '{idx: 4'(m_tail), rd: alloc_rd, done: 1'b0, misp: 1'b0, data: 32'd0};
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % 16;
                end
                m_flush    = e_misp;
                m_rollback = e_misp;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_rd_zero();
        test_mispredict();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
